// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: round-robin, packet-locked sharing of the CDC serial TX port.
// Bytes are discarded (and counted) while the USB host is absent.
module usb_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  input  logic               host_presence,
  input  logic               uart_tx_ready,
  output logic               uart_tx_strobe,
  output logic [7:0]         uart_tx_data,
  output logic [15:0]        drop_count
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [7:0]       burst_q, burst_d;
  logic [7:0]       idle_q, idle_d;
  logic [7:0]       data_q, data_d;
  logic             strobe_q, strobe_d;
  logic             last_q, last_d;
  logic [15:0]      drop_q, drop_d;

  logic             found;
  logic [IW-1:0]    pick;
  logic [IW:0]      sum;
  logic [IW-1:0]    next_ptr;
  logic             own_valid;
  logic             own_last;
  logic [7:0]       own_data;
  logic             consume;
  logic             timeout;
  logic             gap_release;

  // Round-robin search: first valid requester from ptr upward, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(N_REQ)) begin
        sum = sum - (IW+1)'(N_REQ);
      end
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  // Select the current owner's byte, valid and last flags.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[8*i +: 8];
      end
    end
  end

  // Shared decode terms for the FSM and datapath.
  always_comb begin
    next_ptr    = (owner_q == IW'(N_REQ-1)) ? '0 : owner_q + IW'(1);
    consume     = own_valid && (uart_tx_ready || !host_presence);
    timeout     = !own_valid && ((idle_q + 8'd1) == 8'(IDLE_TIMEOUT));
    gap_release = last_q || (burst_q == 8'(MAX_BURST));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (consume) begin
          state_d = S_GAP;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        state_d = gap_release ? S_IDLE : S_SEND;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output and counter updates; ready and strobe are single-cycle pulses.
  always_comb begin
    grant_d  = grant_q;
    ready_d  = '0;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    idle_d   = idle_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    last_d   = last_q;
    drop_d   = drop_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          owner_d       = pick;
          burst_d       = '0;
          idle_d        = '0;
        end
      end
      S_SEND: begin
        if (consume) begin
          ready_d = grant_q;
          last_d  = own_last;
          burst_d = burst_q + 8'd1;
          idle_d  = '0;
          if (host_presence) begin
            strobe_d = 1'b1;
            data_d   = own_data;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end else if (!own_valid) begin
          if (timeout) begin
            grant_d = '0;
            ptr_d   = next_ptr;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 8'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_release) begin
          grant_d = '0;
          ptr_d   = next_ptr;
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q  <= '0;
      ready_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      burst_q  <= '0;
      idle_q   <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      last_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      last_q   <= last_d;
      drop_q   <= drop_d;
    end
  end

  assign grant          = grant_q;
  assign req_ready      = ready_q;
  assign uart_tx_strobe = strobe_q;
  assign uart_tx_data   = data_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb_usb_tx_arbiter: directed scenarios for the USB TX arbiter.
// Producers are byte queues that advance on req_ready.
module tb_usb_tx_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           host_presence = 1'b1;
  logic           uart_tx_ready = 1'b1;
  logic           uart_tx_strobe;
  logic [7:0]     uart_tx_data;
  logic [15:0]    drop_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rel_cyc = -1;
  logic [N-1:0] hold = '0;
  logic [N-1:0] prev_grant = '0;
  int rdy_cnt [N];

  logic [8:0] pq0 [$];
  logic [8:0] pq1 [$];
  logic [8:0] pq2 [$];
  logic [7:0] lg_d [$];
  int         lg_s [$];
  int         lg_c [$];

  usb_tx_arbiter #(
    .N_REQ(N),
    .MAX_BURST(4),
    .IDLE_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant(grant),
    .host_presence(host_presence),
    .uart_tx_ready(uart_tx_ready),
    .uart_tx_strobe(uart_tx_strobe),
    .uart_tx_data(uart_tx_data),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int oh2i(input logic [N-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) begin
      if (g[i]) r = i;
    end
    return r;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic l);
    case (r)
      0: pq0.push_back({l, d});
      1: pq1.push_back({l, d});
      default: pq2.push_back({l, d});
    endcase
  endtask

  // Producers: pop on req_ready, then present the queue head.
  initial forever begin
    @(negedge clk);
    if (req_ready[0] && pq0.size() > 0) pq0.delete(0);
    if (req_ready[1] && pq1.size() > 0) pq1.delete(0);
    if (req_ready[2] && pq2.size() > 0) pq2.delete(0);
    if (pq0.size() > 0 && !hold[0]) begin
      req_valid[0] = 1'b1;
      req_data[7:0] = pq0[0][7:0];
      req_last[0] = pq0[0][8];
    end else begin
      req_valid[0] = 1'b0;
      req_last[0] = 1'b0;
    end
    if (pq1.size() > 0 && !hold[1]) begin
      req_valid[1] = 1'b1;
      req_data[15:8] = pq1[0][7:0];
      req_last[1] = pq1[0][8];
    end else begin
      req_valid[1] = 1'b0;
      req_last[1] = 1'b0;
    end
    if (pq2.size() > 0 && !hold[2]) begin
      req_valid[2] = 1'b1;
      req_data[23:16] = pq2[0][7:0];
      req_last[2] = pq2[0][8];
    end else begin
      req_valid[2] = 1'b0;
      req_last[2] = 1'b0;
    end
  end

  // Monitor: log strobes, count ready pulses, note grant release cycle.
  initial forever begin
    @(negedge clk);
    total++;
    if (!$onehot0(grant)) begin
      bad++;
      $display("FAIL grant_onehot got=%b want=zero-or-onehot", grant);
    end
    if (uart_tx_strobe) begin
      lg_d.push_back(uart_tx_data);
      lg_s.push_back(oh2i(grant));
      lg_c.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) rdy_cnt[i]++;
    end
    if (prev_grant != '0 && grant == '0) rel_cyc = cyc;
    prev_grant = grant;
  end

  task automatic reset_dut(input logic hp);
    @(negedge clk);
    reset = 1'b1;
    hold = '0;
    host_presence = hp;
    uart_tx_ready = 1'b1;
    pq0.delete();
    pq1.delete();
    pq2.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lg_d.delete();
    lg_s.delete();
    lg_c.delete();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    rel_cyc = -1;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (pq0.size() == 0 && pq1.size() == 0 &&
          pq2.size() == 0 && grant == '0) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if (grant !== '0) begin
      bad++; $display("FAIL rst_grant got=%b want=0", grant);
    end
    total++;
    if (req_ready !== '0) begin
      bad++; $display("FAIL rst_ready got=%b want=0", req_ready);
    end
    total++;
    if (uart_tx_strobe !== 1'b0) begin
      bad++; $display("FAIL rst_strobe got=%b want=0", uart_tx_strobe);
    end
    total++;
    if (uart_tx_data !== 8'h00) begin
      bad++; $display("FAIL rst_data got=%h want=00", uart_tx_data);
    end
    total++;
    if (drop_count !== 16'h0) begin
      bad++; $display("FAIL rst_drop got=%h want=0000", drop_count);
    end
    push(0, 8'h11, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (grant !== '0) begin
      bad++; $display("FAIL rst_hold_grant got=%b want=0", grant);
    end
    pq0.delete();
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] ed [3] = '{8'h41, 8'h42, 8'h43};
    reset_dut(1'b1);
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    wait_idle(100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_done got=timeout want=idle");
    end
    total++;
    if (rdy_cnt[0] != 3) begin
      bad++; $display("FAIL single_ready got=%0d want=3", rdy_cnt[0]);
    end
    total++;
    if (lg_d.size() != 3) begin
      bad++; $display("FAIL single_count got=%0d want=3", lg_d.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (lg_d[k] !== ed[k] || lg_s[k] != 0) begin
          bad++;
          $display("FAIL single_byte%0d got=%h/src%0d want=%h/src0",
                   k, lg_d[k], lg_s[k], ed[k]);
        end
      end
      for (int k = 1; k < 3; k++) begin
        total++;
        if (lg_c[k] - lg_c[k-1] != 2) begin
          bad++;
          $display("FAIL single_gap%0d got=%0d want=2",
                   k, lg_c[k] - lg_c[k-1]);
        end
      end
      total++;
      if (rel_cyc - lg_c[2] != 1) begin
        bad++;
        $display("FAIL single_release got=%0d want=1", rel_cyc - lg_c[2]);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] ed [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h03,
                            8'h04, 8'h13, 8'h14, 8'h05, 8'h06};
    int es [10] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
    reset_dut(1'b1);
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
    push(0, 8'h03, 1'b0); push(0, 8'h04, 1'b1);
    push(0, 8'h05, 1'b0); push(0, 8'h06, 1'b1);
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
    push(1, 8'h13, 1'b0); push(1, 8'h14, 1'b1);
    wait_idle(200, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rr_done got=timeout want=idle");
    end
    total++;
    if (lg_d.size() != 10) begin
      bad++; $display("FAIL rr_count got=%0d want=10", lg_d.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        total++;
        if (lg_d[k] !== ed[k] || lg_s[k] != es[k]) begin
          bad++;
          $display("FAIL rr_byte%0d got=%h/src%0d want=%h/src%0d",
                   k, lg_d[k], lg_s[k], ed[k], es[k]);
        end
      end
    end
  endtask

  task automatic test_burst();
    bit ok;
    logic [7:0] ed [12] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61,
                            8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
    int es [12] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    reset_dut(1'b1);
    for (int k = 0; k < 10; k++) push(0, 8'h50 + 8'(k), 1'b0);
    push(1, 8'h60, 1'b0);
    push(1, 8'h61, 1'b1);
    wait_idle(300, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL burst_done got=timeout want=idle");
    end
    total++;
    if (lg_d.size() != 12) begin
      bad++; $display("FAIL burst_count got=%0d want=12", lg_d.size());
    end else begin
      for (int k = 0; k < 12; k++) begin
        total++;
        if (lg_d[k] !== ed[k] || lg_s[k] != es[k]) begin
          bad++;
          $display("FAIL burst_byte%0d got=%h/src%0d want=%h/src%0d",
                   k, lg_d[k], lg_s[k], ed[k], es[k]);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    bit seen;
    int nstb, nrdy, ngr;
    reset_dut(1'b1);
    push(0, 8'h70, 1'b0); push(0, 8'h71, 1'b0);
    push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uart_tx_strobe && uart_tx_data == 8'h71) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL bp_second got=timeout want=strobe 71");
    end
    uart_tx_ready = 1'b0;
    nstb = 0; nrdy = 0; ngr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (uart_tx_strobe) nstb++;
      if (req_ready != '0) nrdy++;
      if (grant != 3'b001) ngr++;
    end
    total++;
    if (nstb != 0) begin
      bad++; $display("FAIL bp_strobe got=%0d want=0", nstb);
    end
    total++;
    if (nrdy != 0) begin
      bad++; $display("FAIL bp_ready got=%0d want=0", nrdy);
    end
    total++;
    if (ngr != 0) begin
      bad++; $display("FAIL bp_grant got=%0d lost-cycles want=0", ngr);
    end
    // SEND is waiting, so the edge that samples ready high consumes.
    uart_tx_ready = 1'b1;
    @(negedge clk);
    total++;
    if (uart_tx_strobe !== 1'b1 || uart_tx_data !== 8'h72) begin
      bad++;
      $display("FAIL bp_resume got=%b/%h want=1/72",
               uart_tx_strobe, uart_tx_data);
    end
    wait_idle(100, ok);
    total++;
    if (!ok || lg_d.size() != 4 || rdy_cnt[0] != 4) begin
      bad++;
      $display("FAIL bp_total got=%0d strobes/%0d readies want=4/4",
               lg_d.size(), rdy_cnt[0]);
    end
  endtask

  task automatic test_host_absent();
    bit ok;
    reset_dut(1'b0);
    for (int k = 0; k < 5; k++) push(1, 8'h80 + 8'(k), k == 4);
    wait_idle(100, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL drop_done got=timeout want=idle");
    end
    total++;
    if (rdy_cnt[1] != 5) begin
      bad++; $display("FAIL drop_ready got=%0d want=5", rdy_cnt[1]);
    end
    total++;
    if (lg_d.size() != 0) begin
      bad++; $display("FAIL drop_strobes got=%0d want=0", lg_d.size());
    end
    total++;
    if (drop_count !== 16'd5) begin
      bad++; $display("FAIL drop_count got=%0d want=5", drop_count);
    end
    force dut.drop_q = 16'hFFFE;
    #1 release dut.drop_q;
    #1;
    total++;
    if (drop_count !== 16'hFFFE) begin
      bad++; $display("FAIL drop_preset got=%h want=fffe", drop_count);
    end
    push(2, 8'h85, 1'b0);
    push(2, 8'h86, 1'b1);
    wait_idle(100, ok);
    total++;
    if (!ok || rdy_cnt[2] != 2) begin
      bad++; $display("FAIL drop_sat_ready got=%0d want=2", rdy_cnt[2]);
    end
    total++;
    if (drop_count !== 16'hFFFF) begin
      bad++; $display("FAIL drop_sat got=%h want=ffff", drop_count);
    end
  endtask

  task automatic test_timeout_reset();
    bit seen;
    int n;
    reset_dut(1'b1);
    push(0, 8'h90, 1'b0);
    push(0, 8'h91, 1'b0);
    push(0, 8'h92, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uart_tx_strobe && uart_tx_data == 8'h90) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL to_first got=timeout want=strobe 90");
    end
    // Now in GAP; owner withdraws valid. One GAP edge plus 8 idle SEND edges.
    hold[0] = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (grant == '0) break;
    end
    total++;
    if (n != 9) begin
      bad++; $display("FAIL to_release got=%0d edges want=9", n);
    end
    hold[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uart_tx_strobe && uart_tx_data == 8'h91) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL to_resume got=timeout want=strobe 91");
    end
    uart_tx_ready = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 3'b001 || uart_tx_data !== 8'h91) begin
      bad++;
      $display("FAIL to_send got=%b/%h want=001/91", grant, uart_tx_data);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (grant !== '0 || req_ready !== '0) begin
      bad++;
      $display("FAIL async_rst_grant got=%b/%b want=0/0", grant, req_ready);
    end
    total++;
    if (uart_tx_strobe !== 1'b0 || uart_tx_data !== 8'h00 ||
        drop_count !== 16'h0) begin
      bad++;
      $display("FAIL async_rst_out got=%b/%h/%h want=0/00/0000",
               uart_tx_strobe, uart_tx_data, drop_count);
    end
    pq0.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_back_pressure();
    test_host_absent();
    test_timeout_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
